// File: rtl/err_detect_pkg.sv
// Shared types for the sample/Err responder: FSM states and dual-rail encodings.
package err_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WINDOW = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  // Rail pair packed as {Err1, Err0}; 2'b11 is illegal and never produced.
  localparam logic [1:0] RAIL_NONE = 2'b00;
  localparam logic [1:0] RAIL_OK   = 2'b01;
  localparam logic [1:0] RAIL_ERR  = 2'b10;

endpackage

// File: rtl/err_detect_responder_bit_sync.sv
// Reset-to-zero multi-flop synchronizer bringing the asynchronous sample request into clk.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{1'b0}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/err_detect_responder.sv
// Responder for the controller's sample/Err handshake: main/shadow capture, compare, dual-rail answer.
// Optional saturating error counter and err_count port enabled by defining ERR_STATS_EN.
module err_detect_responder
  import err_detect_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int WINDOW      = 3,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample,
  input  logic [DATA_W-1:0] d_in,
  output logic              Err0,
  output logic              Err1,
  output logic [DATA_W-1:0] q_out,
  output logic              q_valid,
  output logic              proto_err
`ifdef ERR_STATS_EN
  ,
  output logic [CNT_W-1:0]  err_count
`endif
);

  localparam int WC_W = $clog2(WINDOW + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WINDOW - 1);

  logic              sample_s;
  state_e            state_q, state_d;
  logic [WC_W-1:0]   win_cnt_q, win_cnt_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [1:0]        rail_q, rail_d;
  logic [DATA_W-1:0] q_out_q, q_out_d;
  logic              q_valid_q, q_valid_d;
  logic              proto_q, proto_d;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sample_sync (
    .clk (clk),
    .rst (rst),
    .d_i (sample),
    .q_o (sample_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      win_cnt_q <= {WC_W{1'b0}};
      main_q    <= {DATA_W{1'b0}};
      rail_q    <= RAIL_NONE;
      q_out_q   <= {DATA_W{1'b0}};
      q_valid_q <= 1'b0;
      proto_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      main_q    <= main_d;
      rail_q    <= rail_d;
      q_out_q   <= q_out_d;
      q_valid_q <= q_valid_d;
      proto_q   <= proto_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    main_d    = main_q;
    rail_d    = rail_q;
    q_out_d   = q_out_q;
    q_valid_d = 1'b0;
    proto_d   = proto_q;
    case (state_q)
      ST_IDLE: begin
        rail_d = RAIL_NONE;
        if (sample_s) begin
          main_d    = d_in;
          win_cnt_d = {WC_W{1'b0}};
          state_d   = ST_WINDOW;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_WINDOW: begin
        // A request withdrawn mid-window wins over a compare landing on the same edge.
        if (!sample_s) begin
          proto_d = 1'b1;
          state_d = ST_IDLE;
        end else if (win_cnt_q == WC_LAST) begin
          if (main_q == d_in) begin
            rail_d  = RAIL_OK;
            q_out_d = main_q;
          end else begin
            rail_d  = RAIL_ERR;
            q_out_d = d_in;
          end
          q_valid_d = 1'b1;
          state_d   = ST_HOLD;
        end else begin
          win_cnt_d = win_cnt_q + WC_W'(1);
        end
      end
      ST_HOLD: begin
        if (!sample_s) begin
          rail_d  = RAIL_NONE;
          state_d = ST_IDLE;
        end else begin
          rail_d  = rail_q;
        end
      end
      default: begin
        rail_d  = RAIL_NONE;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign Err0      = rail_q[0];
  assign Err1      = rail_q[1];
  assign q_out     = q_out_q;
  assign q_valid   = q_valid_q;
  assign proto_err = proto_q;

`ifdef ERR_STATS_EN
  logic [CNT_W-1:0] cnt_q;
  logic             err_hit_s;

  assign err_hit_s = (rail_d == RAIL_ERR) && (rail_q != RAIL_ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else if (err_hit_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign err_count = cnt_q;
`endif

endmodule
